awg_cmd_ctrl: RTL and testbench
===============================

// Module: awg_cmd_ctrl
// PURPOSE
//  Byte-stream command parser and per-channel parameter register file for the AWG.
//  Sits between the UART RX byte stream and the DDS/wave generators.
//  Accepts multi-byte ASCII commands that set wave/freq/amp/phase/sweep per channel.
//  Keeps the legacy single-digit frequency presets on channel 0.
//  Adds a tick-driven frequency sweep per channel.
// PARAMETERS
//  N_CH        2      number of output channels (1..8)
//  FREQ_W      14     frequency word width
//  AMP_W       8      amplitude word width
//  PHASE_W     8      phase word width
//  WAVE_W      5      waveform select width
//  DEF_WAVE    3      reset waveform select, all channels
//  DEF_FREQ    1      reset frequency, all channels
//  DEF_AMP     50     reset amplitude
//  DEF_PHASE   50     reset phase
//  FREQ_MAX    10000  largest legal frequency; sweep wrap point
//  SWEEP_STEP  100    frequency increment per tick while sweeping
// PORTS
//  clk        in   1               system clock
//  rst_n      in   1               asynchronous reset, active low
//  rx_data    in   8               received byte
//  rx_valid   in   1               1-cycle strobe: rx_data is valid
//  tick       in   1               1-cycle sweep strobe (1 Hz from t1s)
//  wave       out  N_CH*WAVE_W     per-channel waveform select; ch0 in the LSBs
//  freq       out  N_CH*FREQ_W     per-channel frequency
//  amp        out  N_CH*AMP_W      per-channel amplitude
//  phase      out  N_CH*PHASE_W    per-channel phase
//  sweep_en   out  N_CH            per-channel sweep enable
//  cmd_ok     out  1               1-cycle pulse: command committed
//  cmd_err    out  1               1-cycle pulse: command rejected
// BEHAVIOUR
//  - Reset: all outputs take their DEF_* values; sweep_en=0; cmd_ok/cmd_err=0; FSM in IDLE.
//  - Grammar: <op><ch><digits><CR|LF>.
//    - op: 'W', 'F', 'A', 'P' or 'S' (uppercase only).
//    - ch: '0'..N_CH-1.
//    - digits: 1 or more decimal digits.
//  - FSM IDLE:
//    - op byte -> CHAN.
//    - '1','2','3','4','0' -> ch0 freq = 1, 524, 100, 1000, 10000 (each clamped to FREQ_MAX); cmd_ok pulse.
//    - CR/LF -> ignored.
//    - any other byte -> cmd_err.
//  - FSM CHAN:
//    - valid channel digit -> NUM, with the accumulator cleared.
//    - any other byte -> cmd_err, back to IDLE.
//  - FSM NUM:
//    - digit: acc = acc*10 + d; acc is 20 bits.
//    - Overflow sets a sticky ovf flag; acc saturates.
//    - CR/LF -> commit or reject, then IDLE.
//    - Any other byte -> cmd_err, IDLE.
//  - ESC (0x1B) in any state -> IDLE, no pulse, no update.
//  - Only bytes with rx_valid=1 advance the FSM.
//  - Commit rules (checked at the terminator):
//    - no digits, ovf set, or value > field max -> cmd_err, no update.
//    - Field max: F=FREQ_MAX; A/P/W = 2^width-1; S=1.
//    - otherwise update the field on that same clock edge.
//    - cmd_ok asserts in the cycle the new value is first visible (1 cycle after the terminator strobe).
//  - Sweep: on tick, every channel with sweep_en=1 gets freq += SWEEP_STEP.
//    - If the sum > FREQ_MAX, freq = 1 (wrap).
//    - Sum is computed at FREQ_W+1 bits, so no silent truncation.
//  - Collision: a freq commit on channel c in the same cycle as tick -> the commit wins for c.
//    - Other channels still sweep.
//  - S commit takes effect on the next tick (no immediate step).
//  - cmd_ok and cmd_err are never asserted together.
//  - rst_n low mid-command: the partial command is discarded and all registers return to defaults.
// STRUCTURE
//  - awg_pkg holds:
//    - ASCII constants (op letters, '0', CR, LF, ESC);
//    - the FSM state encoding (IDLE, CHAN, NUM);
//    - the legacy preset table.
//  - Sub-module awg_dec_accum:
//    - clear/digit/valid in; 20-bit acc, ovf, has_digit out;
//    - one instance.
//  - Register file: N_CH-indexed arrays, flattened onto the output buses.
//  - tick is produced externally by t1s; this block only samples it.
// TESTING
//  1. Reset, then release -> every channel: wave=3, freq=1, amp=50, phase=50; sweep_en=0.
//  2. "F1523\r" -> ch1 freq=523; cmd_ok for 1 cycle; ch0 unchanged.
//  3. "F012000\n" -> cmd_err; freq unchanged. "A0300\r" -> cmd_err (300 > 255).
//  4. Byte '2' in IDLE -> ch0 freq=524, cmd_ok. Byte '0' -> ch0 freq=10000.
//  5. "S01\r", then ch0 freq=9950 and tick -> freq=1. Next tick -> 101.
//  6. "F07" then ESC, then "F02\r" -> freq=2, exactly one cmd_ok.
//  7. "F1", then rst_n low for 2 cycles -> defaults restored; subsequent "A1" + CR -> cmd_err.
//  8. Terminator strobe of "F05\r" in the same cycle as tick with sweep_en[0]=1 -> freq=5.
//  9. "F99\r" with N_CH=2 -> cmd_err (invalid channel).

Source files
------------

// File: rtl/awg_pkg.sv
// rtl/awg_pkg.sv - shared constants, FSM encoding and legacy preset table for the AWG command parser
//   No ports; imported by awg_dec_accum and awg_cmd_ctrl.
package awg_pkg;

  localparam int ACC_W = 20;

  localparam logic [7:0] ASC_W   = 8'h57;
  localparam logic [7:0] ASC_F   = 8'h46;
  localparam logic [7:0] ASC_A   = 8'h41;
  localparam logic [7:0] ASC_P   = 8'h50;
  localparam logic [7:0] ASC_S   = 8'h53;
  localparam logic [7:0] ASC_0   = 8'h30;
  localparam logic [7:0] ASC_4   = 8'h34;
  localparam logic [7:0] ASC_9   = 8'h39;
  localparam logic [7:0] ASC_CR  = 8'h0D;
  localparam logic [7:0] ASC_LF  = 8'h0A;
  localparam logic [7:0] ASC_ESC = 8'h1B;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CHAN = 2'd1,
    S_NUM  = 2'd2
  } state_t;

  // Legacy single-key presets typed in IDLE; they always target channel 0.
  function automatic logic is_preset(input logic [7:0] b);
    return (b >= ASC_0) && (b <= ASC_4);
  endfunction

  function automatic logic [ACC_W-1:0] preset_freq(input logic [7:0] b);
    logic [ACC_W-1:0] f;
    case (b)
      8'h31:   f = 20'd1;
      8'h32:   f = 20'd524;
      8'h33:   f = 20'd100;
      8'h34:   f = 20'd1000;
      8'h30:   f = 20'd10000;
      default: f = 20'd0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/awg_dec_accum.sv
// rtl/awg_dec_accum.sv - saturating 20-bit decimal accumulator for command arguments
//   clk, rst_n      clock, asynchronous active-low reset
//   clear           restart the number (acc=0, ovf=0, has_digit=0)
//   digit, valid    one decimal digit 0..9 to shift in
//   acc             accumulated value, saturates at 2^20-1
//   ovf             sticky: a digit pushed the value past 2^20-1
//   has_digit       at least one digit seen since clear
module awg_dec_accum
  import awg_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [3:0]       digit,
  input  logic             valid,
  output logic [ACC_W-1:0] acc,
  output logic             ovf,
  output logic             has_digit
);

  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  // 24 bits holds (2^20-1)*10+9 without wrapping, so overflow is detected exactly.
  logic [23:0] next_val;
  assign next_val = 24'(acc) * 24'd10 + 24'(digit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      ovf       <= 1'b0;
      has_digit <= 1'b0;
    end else if (clear) begin
      acc       <= '0;
      ovf       <= 1'b0;
      has_digit <= 1'b0;
    end else if (valid) begin
      has_digit <= 1'b1;
      if (ovf || (next_val > 24'(ACC_MAX))) begin
        acc <= ACC_MAX;
        ovf <= 1'b1;
      end else begin
        acc <= next_val[ACC_W-1:0];
      end
    end
  end

endmodule

// File: rtl/awg_cmd_ctrl.sv
// rtl/awg_cmd_ctrl.sv - ASCII command parser and per-channel AWG parameter register file with tick sweep
//   clk, rst_n      clock, asynchronous active-low reset
//   rx_data/valid   received byte and its 1-cycle strobe
//   tick            1-cycle sweep strobe
//   wave/freq/amp/phase  per-channel parameters, channel 0 in the LSBs
//   sweep_en        per-channel sweep enable
//   cmd_ok/cmd_err  1-cycle pulses: command committed / rejected
module awg_cmd_ctrl
  import awg_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int FREQ_W     = 14,
  parameter int AMP_W      = 8,
  parameter int PHASE_W    = 8,
  parameter int WAVE_W     = 5,
  parameter int DEF_WAVE   = 3,
  parameter int DEF_FREQ   = 1,
  parameter int DEF_AMP    = 50,
  parameter int DEF_PHASE  = 50,
  parameter int FREQ_MAX   = 10000,
  parameter int SWEEP_STEP = 100
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  input  logic                    tick,
  output logic [N_CH*WAVE_W-1:0]  wave,
  output logic [N_CH*FREQ_W-1:0]  freq,
  output logic [N_CH*AMP_W-1:0]   amp,
  output logic [N_CH*PHASE_W-1:0] phase,
  output logic [N_CH-1:0]         sweep_en,
  output logic                    cmd_ok,
  output logic                    cmd_err
);

  localparam logic [ACC_W-1:0] FREQ_MAX_A = ACC_W'(FREQ_MAX);

  state_t             state;
  logic [7:0]         op_r;
  logic [2:0]         ch_r;
  logic [WAVE_W-1:0]  wave_r  [N_CH];
  logic [FREQ_W-1:0]  freq_r  [N_CH];
  logic [AMP_W-1:0]   amp_r   [N_CH];
  logic [PHASE_W-1:0] phase_r [N_CH];
  logic [N_CH-1:0]    sweep_r;

  logic [ACC_W-1:0] acc;
  logic             ovf, has_digit;
  logic             is_digit, is_term, is_esc, is_op, ch_ok, commit_good;
  logic [ACC_W-1:0] field_max, preset_p, preset_val;

  always_comb begin
    is_digit = (rx_data >= ASC_0) && (rx_data <= ASC_9);
    is_term  = (rx_data == ASC_CR) || (rx_data == ASC_LF);
    is_esc   = (rx_data == ASC_ESC);
    is_op    = (rx_data == ASC_W) || (rx_data == ASC_F) || (rx_data == ASC_A) ||
               (rx_data == ASC_P) || (rx_data == ASC_S);
    ch_ok    = is_digit && (int'(rx_data[3:0]) < N_CH);
    case (op_r)
      ASC_F:   field_max = FREQ_MAX_A;
      ASC_A:   field_max = ACC_W'((1 << AMP_W) - 1);
      ASC_P:   field_max = ACC_W'((1 << PHASE_W) - 1);
      ASC_W:   field_max = ACC_W'((1 << WAVE_W) - 1);
      default: field_max = 20'd1;
    endcase
    commit_good = has_digit && !ovf && (acc <= field_max);
    preset_p    = preset_freq(rx_data);
    preset_val  = (preset_p > FREQ_MAX_A) ? FREQ_MAX_A : preset_p;
  end

  awg_dec_accum u_accum (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (rx_valid && (state == S_CHAN) && ch_ok),
    .digit     (rx_data[3:0]),
    .valid     (rx_valid && (state == S_NUM) && is_digit),
    .acc       (acc),
    .ovf       (ovf),
    .has_digit (has_digit)
  );

  // One extra bit on the sum so a step past FREQ_MAX is seen, never truncated.
  function automatic logic [FREQ_W-1:0] sweep_next(input logic [FREQ_W-1:0] f);
    logic [FREQ_W:0] sum;
    sum = {1'b0, f} + (FREQ_W+1)'(SWEEP_STEP);
    return (sum > (FREQ_W+1)'(FREQ_MAX)) ? FREQ_W'(1) : sum[FREQ_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      op_r    <= '0;
      ch_r    <= '0;
      sweep_r <= '0;
      cmd_ok  <= 1'b0;
      cmd_err <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        wave_r[i]  <= WAVE_W'(DEF_WAVE);
        freq_r[i]  <= FREQ_W'(DEF_FREQ);
        amp_r[i]   <= AMP_W'(DEF_AMP);
        phase_r[i] <= PHASE_W'(DEF_PHASE);
      end
    end else begin
      cmd_ok  <= 1'b0;
      cmd_err <= 1'b0;
      // Sweep first; a frequency write below on the same edge overrides it for that channel.
      if (tick) begin
        for (int i = 0; i < N_CH; i++)
          if (sweep_r[i]) freq_r[i] <= sweep_next(freq_r[i]);
      end
      if (rx_valid) begin
        if (is_esc) begin
          state <= S_IDLE;
        end else begin
          case (state)
            S_IDLE: begin
              if (is_op) begin
                op_r  <= rx_data;
                state <= S_CHAN;
              end else if (is_preset(rx_data)) begin
                freq_r[0] <= preset_val[FREQ_W-1:0];
                cmd_ok    <= 1'b1;
              end else if (!is_term) begin
                cmd_err <= 1'b1;
              end
            end
            S_CHAN: begin
              if (ch_ok) begin
                ch_r  <= rx_data[2:0];
                state <= S_NUM;
              end else begin
                cmd_err <= 1'b1;
                state   <= S_IDLE;
              end
            end
            S_NUM: begin
              if (is_term) begin
                state <= S_IDLE;
                if (commit_good) begin
                  cmd_ok <= 1'b1;
                  for (int i = 0; i < N_CH; i++) begin
                    if (ch_r == 3'(i)) begin
                      case (op_r)
                        ASC_F:   freq_r[i]  <= acc[FREQ_W-1:0];
                        ASC_A:   amp_r[i]   <= acc[AMP_W-1:0];
                        ASC_P:   phase_r[i] <= acc[PHASE_W-1:0];
                        ASC_W:   wave_r[i]  <= acc[WAVE_W-1:0];
                        default: sweep_r[i] <= acc[0];
                      endcase
                    end
                  end
                end else begin
                  cmd_err <= 1'b1;
                end
              end else if (!is_digit) begin
                cmd_err <= 1'b1;
                state   <= S_IDLE;
              end
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_flat
    assign wave[g*WAVE_W +: WAVE_W]    = wave_r[g];
    assign freq[g*FREQ_W +: FREQ_W]    = freq_r[g];
    assign amp[g*AMP_W +: AMP_W]       = amp_r[g];
    assign phase[g*PHASE_W +: PHASE_W] = phase_r[g];
  end
  assign sweep_en = sweep_r;

endmodule

// File: tb/tb_awg_cmd_ctrl.sv
// tb/tb_awg_cmd_ctrl.sv - directed self-checking bench for awg_cmd_ctrl
module tb_awg_cmd_ctrl;

  localparam int N_CH = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          tick = 1'b0;
  logic [9:0]    wave;
  logic [27:0]   freq;
  logic [15:0]   amp;
  logic [15:0]   phase;
  logic [1:0]    sweep_en;
  logic          cmd_ok, cmd_err;

  int checks = 0;
  int failures = 0;
  int ok_cnt = 0, err_cnt = 0, both_cnt = 0;
  int ok0, err0;

  awg_cmd_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .tick(tick),
    .wave(wave), .freq(freq), .amp(amp), .phase(phase), .sweep_en(sweep_en),
    .cmd_ok(cmd_ok), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmd_ok) ok_cnt++;
    if (cmd_err) err_cnt++;
    if (cmd_ok && cmd_err) both_cnt++;
  end

  function automatic logic [13:0] f_of(int c); return freq[c*14 +: 14]; endfunction
  function automatic logic [4:0]  w_of(int c); return wave[c*5 +: 5];   endfunction
  function automatic logic [7:0]  a_of(int c); return amp[c*8 +: 8];    endfunction
  function automatic logic [7:0]  p_of(int c); return phase[c*8 +: 8];  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic pulse_tick();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
  endtask

  task automatic snap();
    ok0 = ok_cnt; err0 = err_cnt;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < N_CH; c++) begin
      chk($sformatf("reset_wave%0d", c), int'(w_of(c)), 3);
      chk($sformatf("reset_freq%0d", c), int'(f_of(c)), 1);
      chk($sformatf("reset_amp%0d", c), int'(a_of(c)), 50);
      chk($sformatf("reset_phase%0d", c), int'(p_of(c)), 50);
    end
    chk("reset_sweep_en", int'(sweep_en), 0);
    chk("reset_pulses", int'({cmd_ok, cmd_err}), 0);
  endtask

  task automatic test_freq_cmd();
    snap();
    send_str("F1523\r");
    #1;
    chk("f1523_ok_now", int'(cmd_ok), 1);
    chk("f1523_freq1_now", int'(f_of(1)), 523);
    idle(2);
    chk("f1523_ok_count", ok_cnt - ok0, 1);
    chk("f1523_err_count", err_cnt - err0, 0);
    chk("f1523_freq0", int'(f_of(0)), 1);
  endtask

  task automatic test_range();
    snap();
    send_str("F012000\n"); idle(2);
    chk("f12000_err", err_cnt - err0, 1);
    chk("f12000_freq0", int'(f_of(0)), 1);
    snap();
    send_str("A0300\r"); idle(2);
    chk("a300_err", err_cnt - err0, 1);
    chk("a300_amp0", int'(a_of(0)), 50);
    snap();
    send_str("W131\r"); send_str("P0255\r"); idle(2);
    chk("wave_max_ok", ok_cnt - ok0, 2);
    chk("wave1_31", int'(w_of(1)), 31);
    chk("phase0_255", int'(p_of(0)), 255);
  endtask

  task automatic test_presets();
    snap();
    send_byte("2"); idle(2);
    chk("preset2_freq", int'(f_of(0)), 524);
    chk("preset2_ok", ok_cnt - ok0, 1);
    send_byte("0"); idle(2);
    chk("preset0_freq", int'(f_of(0)), 10000);
    snap();
    send_byte("9"); idle(2);
    chk("preset9_err", err_cnt - err0, 1);
    chk("preset9_freq", int'(f_of(0)), 10000);
  endtask

  task automatic test_sweep();
    send_str("S01\r"); idle(1);
    chk("sweep_en_01", int'(sweep_en), 1);
    send_str("F09950\r"); idle(1);
    chk("sweep_start", int'(f_of(0)), 9950);
    pulse_tick(); idle(1);
    chk("sweep_wrap", int'(f_of(0)), 1);
    chk("sweep_ch1_off", int'(f_of(1)), 523);
    pulse_tick(); idle(1);
    chk("sweep_step", int'(f_of(0)), 101);
  endtask

  task automatic test_escape();
    snap();
    send_str("F07"); send_byte(8'h1B); send_str("F02\r"); idle(2);
    chk("esc_freq", int'(f_of(0)), 2);
    chk("esc_ok_count", ok_cnt - ok0, 1);
    chk("esc_err_count", err_cnt - err0, 0);
  endtask

  task automatic test_collision();
    send_str("S11\r"); idle(1);
    chk("sweep_en_11", int'(sweep_en), 3);
    send_str("F05");
    @(negedge clk);
    rx_data = 8'h0D; rx_valid = 1'b1; tick = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; tick = 1'b0;
    idle(1);
    chk("collide_freq0", int'(f_of(0)), 5);
    chk("collide_freq1", int'(f_of(1)), 623);
  endtask

  task automatic test_bad_channel();
    snap();
    // The second '9' arrives back in IDLE and is itself an illegal byte there.
    send_str("F99\r"); idle(2);
    chk("badch_err", err_cnt - err0, 2);
    chk("badch_ok", ok_cnt - ok0, 0);
    chk("badch_freq0", int'(f_of(0)), 5);
    snap();
    send_str("F1\r"); idle(2);
    chk("nodigit_err", err_cnt - err0, 1);
    chk("nodigit_freq1", int'(f_of(1)), 623);
  endtask

  task automatic test_reset_mid();
    send_str("F1");
    do_reset();
    chk("mid_freq0", int'(f_of(0)), 1);
    chk("mid_freq1", int'(f_of(1)), 1);
    chk("mid_wave1", int'(w_of(1)), 3);
    chk("mid_phase0", int'(p_of(0)), 50);
    chk("mid_sweep_en", int'(sweep_en), 0);
    snap();
    send_str("A1\r"); idle(2);
    chk("mid_a1_err", err_cnt - err0, 1);
    chk("mid_a1_ok", ok_cnt - ok0, 0);
    chk("mid_amp1", int'(a_of(1)), 50);
  endtask

  task automatic test_exclusive();
    chk("ok_err_overlap", both_cnt, 0);
  endtask

  initial begin
    test_reset();
    test_freq_cmd();
    test_range();
    test_presets();
    test_sweep();
    test_escape();
    test_collision();
    test_bad_channel();
    test_reset_mid();
    test_exclusive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
